thr_frame_sequencer: RTL

- Streams one frame of 8-bit grayscale pixels in, assembles it into the flat frame bus consumed by the combinational local-mean threshold stage, and waits a fixed settle time.
- Captures the stage's per-pixel mask and streams it out as one binary bit per pixel.
- Sits between the pixel source and the text-extraction back end, giving the threshold stage its only clocked, flow-controlled front/back door.

---
 rtl/thr_ctrl_pkg.sv | 20 ++
 rtl/thr_bit_serializer.sv | 77 +++++++
 rtl/thr_frame_sequencer.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/thr_ctrl_pkg.sv
// Shared types and helpers for the threshold-stage frame sequencer.
package thr_ctrl_pkg;

    // Sequencer phases: gather a frame, let the threshold stage settle, stream the mask out.
    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        COMPUTE = 2'd1,
        DRAIN   = 2'd2
    } state_e;

    localparam int unsigned PIX_W_DEFAULT = 8;

    // LSB position of pixel slot k in a flat frame; pixel 0 lives in the MSBs.
    function automatic int unsigned slot_lsb(input int unsigned frame_w,
                                             input int unsigned pix_w,
                                             input int unsigned k);
        return frame_w - ((k + 32'd1) * pix_w);
    endfunction

endpackage

// File: rtl/thr_bit_serializer.sv
// Streams the captured per-pixel result out one bit per handshake, with a
// last marker on the final pixel and a done pulse on the final transfer.
module thr_bit_serializer #(
    parameter int unsigned NPIX  = 9,
    parameter int unsigned IDX_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_i,
    input  logic [NPIX-1:0] result_i,
    input  logic            out_ready,
    output logic            out_valid,
    output logic            out_bit,
    output logic            out_last,
    output logic            done_o
);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NPIX - 1);

    logic [IDX_W-1:0] idx_q, idx_d, idx_nxt_s;
    logic             valid_q, valid_d;
    logic             bit_q, bit_d;
    logic             last_q, last_d;
    logic             xfer_s;

    assign xfer_s    = valid_q && out_ready;
    assign idx_nxt_s = idx_q + IDX_W'(1);
    assign done_o    = xfer_s && (idx_q == IDX_LAST);

    // Next output beat: start on load, advance on handshake, hold under backpressure.
    always_comb begin
        idx_d   = idx_q;
        valid_d = valid_q;
        bit_d   = bit_q;
        last_d  = last_q;
        if (load_i) begin
            idx_d   = '0;
            valid_d = 1'b1;
            bit_d   = result_i[0];
            last_d  = (IDX_LAST == '0);
        end else if (xfer_s) begin
            if (idx_q == IDX_LAST) begin
                idx_d   = '0;
                valid_d = 1'b0;
                bit_d   = 1'b0;
                last_d  = 1'b0;
            end else begin
                idx_d   = idx_nxt_s;
                valid_d = 1'b1;
                bit_d   = result_i[idx_nxt_s];
                last_d  = (idx_nxt_s == IDX_LAST);
            end
        end else begin
            idx_d   = idx_q;
            valid_d = valid_q;
        end
    end

    // Output beat registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q   <= '0;
            valid_q <= 1'b0;
            bit_q   <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            valid_q <= valid_d;
            bit_q   <= bit_d;
            last_q  <= last_d;
        end
    end

    assign out_valid = valid_q;
    assign out_bit   = bit_q;
    assign out_last  = last_q;

endmodule

// File: rtl/thr_frame_sequencer.sv
// Frame sequencer in front of the combinational local-mean threshold stage:
// loads a raster frame, holds it for SETTLE cycles, captures the mask MSBs
// and streams them out. Optional in_last cross-check: define THR_LAST_CHECK_EN.
module thr_frame_sequencer
    import thr_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH  = 3,
    parameter int unsigned HEIGHT = 3,
    parameter int unsigned PIX_W  = PIX_W_DEFAULT,
    parameter int unsigned SETTLE = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [PIX_W-1:0]                in_pixel,
    output logic [WIDTH*HEIGHT*PIX_W-1:0]   frame_o,
    input  logic [WIDTH*HEIGHT*PIX_W-1:0]   mask_i,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic                            out_bit,
    output logic                            out_last,
    output logic                            busy
`ifdef THR_LAST_CHECK_EN
    ,
    input  logic                            in_last,
    output logic                            err_o
`endif
);
    localparam int unsigned NPIX    = WIDTH * HEIGHT;
    localparam int unsigned FRAME_W = NPIX * PIX_W;
    localparam int unsigned CNT_W   = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int unsigned SET_W   = $clog2(SETTLE + 1);
    localparam logic [CNT_W-1:0] PIX_LAST = CNT_W'(NPIX - 1);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   pix_cnt_q, pix_cnt_d;
    logic [SET_W-1:0]   settle_cnt_q, settle_cnt_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic [NPIX-1:0]    result_q, result_d, mask_msb_s;
    logic               in_ready_q, in_ready_d;
    logic               busy_q, busy_d;
    logic               xfer_s, last_pix_s, capture_s, done_s;
    logic               mask_unused_s;

    assign xfer_s     = (state_q == LOAD) && in_valid && in_ready_q;
    assign last_pix_s = (pix_cnt_q == PIX_LAST);
    assign capture_s  = (state_q == COMPUTE) && (settle_cnt_q == SET_LAST);

    // Only the MSB of each mask group carries the decision; the rest is ignored.
    assign mask_unused_s = ^mask_i;

    // Pick the decision bit out of every mask group.
    always_comb begin
        mask_msb_s = '0;
        for (int unsigned k = 0; k < NPIX; k++) begin
            mask_msb_s[k] = mask_i[slot_lsb(FRAME_W, PIX_W, k) + PIX_W - 1];
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD: begin
                if (xfer_s && last_pix_s) state_d = COMPUTE;
                else                      state_d = LOAD;
            end
            COMPUTE: begin
                if (capture_s) state_d = DRAIN;
                else           state_d = COMPUTE;
            end
            DRAIN: begin
                if (done_s) state_d = LOAD;
                else        state_d = DRAIN;
            end
            default: state_d = LOAD;
        endcase
    end

    // Datapath and registered-output next values for each phase.
    always_comb begin
        pix_cnt_d    = pix_cnt_q;
        settle_cnt_d = settle_cnt_q;
        frame_d      = frame_q;
        result_d     = capture_s ? mask_msb_s : result_q;
        in_ready_d   = 1'b0;
        busy_d       = (state_d == COMPUTE) || (state_d == DRAIN);
        for (int unsigned k = 0; k < NPIX; k++) begin
            if (xfer_s && (pix_cnt_q == CNT_W'(k))) begin
                frame_d[slot_lsb(FRAME_W, PIX_W, k) +: PIX_W] = in_pixel;
            end else begin
                frame_d[slot_lsb(FRAME_W, PIX_W, k) +: PIX_W] = frame_q[slot_lsb(FRAME_W, PIX_W, k) +: PIX_W];
            end
        end
        case (state_q)
            LOAD: begin
                if (xfer_s && last_pix_s) begin
                    pix_cnt_d    = '0;
                    settle_cnt_d = '0;
                    in_ready_d   = 1'b0;
                end else if (xfer_s) begin
                    pix_cnt_d  = pix_cnt_q + CNT_W'(1);
                    in_ready_d = 1'b1;
                end else begin
                    in_ready_d = 1'b1;
                end
            end
            COMPUTE: begin
                settle_cnt_d = settle_cnt_q + SET_W'(1);
                in_ready_d   = 1'b0;
            end
            DRAIN: begin
                in_ready_d = done_s;
            end
            default: begin
                in_ready_d = 1'b0;
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_cnt_q    <= '0;
            settle_cnt_q <= '0;
            frame_q      <= '0;
            result_q     <= '0;
            in_ready_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            pix_cnt_q    <= pix_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            frame_q      <= frame_d;
            result_q     <= result_d;
            in_ready_q   <= in_ready_d;
            busy_q       <= busy_d;
        end
    end

`ifdef THR_LAST_CHECK_EN
    logic err_q, err_d;

    // Sticky flag when the source's frame-end marker disagrees with the pixel count.
    always_comb begin
        if (xfer_s && (in_last != last_pix_s)) err_d = 1'b1;
        else                                   err_d = err_q;
    end

    // Error flag register.
    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end

    assign err_o = err_q;
`endif

    thr_bit_serializer #(
        .NPIX  (NPIX),
        .IDX_W (CNT_W)
    ) u_ser (
        .clk       (clk),
        .rst       (rst),
        .load_i    (capture_s),
        .result_i  (result_d),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_bit   (out_bit),
        .out_last  (out_last),
        .done_o    (done_s)
    );

    assign frame_o  = frame_q;
    assign in_ready = in_ready_q;
    assign busy     = busy_q;

endmodule
